// File: rtl/btn_conditioner_if.sv
// btn_conditioner_if: raw push-button inputs and conditioned pulse/level outputs
//   btnL/btnR/btnD/btnU          raw asynchronous buttons, active-high
//   btnL_p/btnR_p/btnD_p/btnU_p  one-cycle move/rotate pulses
//   btnL_db/.../btnU_db          debounced levels
//   master: board/bench side, slave: conditioner side
interface btn_conditioner_if;
    logic btnL, btnR, btnD, btnU;
    logic btnL_p, btnR_p, btnD_p, btnU_p;
    logic btnL_db, btnR_db, btnD_db, btnU_db;
    modport master (
        output btnL, btnR, btnD, btnU,
        input  btnL_p, btnR_p, btnD_p, btnU_p,
        input  btnL_db, btnR_db, btnD_db, btnU_db
    );
    modport slave (
        input  btnL, btnR, btnD, btnU,
        output btnL_p, btnR_p, btnD_p, btnU_p,
        output btnL_db, btnR_db, btnD_db, btnU_db
    );
endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronise, debounce and pulse-convert four push-buttons
//   pclk  only clock
//   rst   synchronous active-high reset
//   bus   btn_conditioner_if.slave: raw buttons in, pulses and debounced levels out
// L, R and D auto-repeat while held; U pulses once per press.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 750000,
    parameter int REPEAT_DELAY    = 22500000,
    parameter int REPEAT_PERIOD   = 7500000
) (
    input logic              pclk,
    input logic              rst,
    btn_conditioner_if.slave bus
);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int RW   = $clog2(RMAX);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    // channel order: 0 = L, 1 = R, 2 = D, 3 = U
    logic [3:0] raw, db_w, dbo_w, p_w;

    assign raw = {bus.btnU, bus.btnD, bus.btnR, bus.btnL};

    assign bus.btnL_p  = p_w[0];
    assign bus.btnR_p  = p_w[1];
    assign bus.btnD_p  = p_w[2];
    assign bus.btnU_p  = p_w[3];
    assign bus.btnL_db = dbo_w[0];
    assign bus.btnR_db = dbo_w[1];
    assign bus.btnD_db = dbo_w[2];
    assign bus.btnU_db = dbo_w[3];

    for (genvar g = 0; g < 4; g++) begin : g_ch
        localparam bit REP = (g != 3);
        localparam bit LR  = (g < 2);
        logic          s1_q, s2_q, db_q, dbo_q, p_q, mute;
        logic [DW-1:0] dc_q;
        logic [RW-1:0] rc_q;
        state_t        st_q;
        // db_q is what dbo_q and the pulse register will show after this edge,
        // so muting on it keeps the pulse and the visible levels consistent
        assign mute = LR && db_w[0] && db_w[1];
        always_ff @(posedge pclk) begin
            if (rst) begin
                s1_q  <= 1'b0;
                s2_q  <= 1'b0;
                db_q  <= 1'b0;
                dbo_q <= 1'b0;
                p_q   <= 1'b0;
                dc_q  <= '0;
                rc_q  <= '0;
                st_q  <= IDLE;
            end else begin
                s1_q  <= raw[g];
                s2_q  <= s1_q;
                dbo_q <= db_q;
                p_q   <= 1'b0;
                if (s2_q == db_q) begin
                    dc_q <= '0;
                end else if (dc_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                    db_q <= s2_q;
                    dc_q <= '0;
                end else begin
                    dc_q <= dc_q + 1'b1;
                end
                // release wins over any repeat pulse due on the same edge
                if (!db_q) begin
                    st_q <= IDLE;
                    rc_q <= '0;
                end else begin
                    case (st_q)
                        IDLE: begin
                            p_q  <= !mute;
                            rc_q <= '0;
                            st_q <= DELAY;
                        end
                        DELAY: begin
                            if (REP && rc_q == RW'(REPEAT_DELAY - 1)) begin
                                p_q  <= !mute;
                                rc_q <= '0;
                                st_q <= REPEAT;
                            end else if (REP) begin
                                rc_q <= rc_q + 1'b1;
                            end
                        end
                        REPEAT: begin
                            if (rc_q == RW'(REPEAT_PERIOD - 1)) begin
                                p_q  <= !mute;
                                rc_q <= '0;
                            end else begin
                                rc_q <= rc_q + 1'b1;
                            end
                        end
                        default: st_q <= IDLE;
                    endcase
                end
            end
        end
        assign db_w[g]  = db_q;
        assign dbo_w[g] = dbo_q;
        assign p_w[g]   = p_q;
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed bench with a per-channel pulse-time scoreboard
module tb_btn_conditioner;
    logic pclk = 1'b0;
    logic rst  = 1'b1;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_q[4][$];
    logic [3:0] p, db;

    btn_conditioner_if bus();

    btn_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3)
    ) dut (
        .pclk(pclk),
        .rst(rst),
        .bus(bus)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    assign p  = {bus.btnU_p, bus.btnD_p, bus.btnR_p, bus.btnL_p};
    assign db = {bus.btnU_db, bus.btnD_db, bus.btnR_db, bus.btnL_db};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic go(input int n);
        while (cyc < n) @(negedge pclk);
    endtask

    // expected pulse cycles: first at p0, then +10, then every +3, up to last;
    // pulses inside [glo,ghi] are suppressed by the L/R conflict
    task automatic push_sched(input int c, input int p0, input int last, input bit rep,
                              input int glo, input int ghi);
        int t = p0;
        while (t <= last) begin
            if (!(t >= glo && t <= ghi)) exp_q[c].push_back(t);
            if (!rep) break;
            t += (t == p0) ? 10 : 3;
        end
    endtask

    always @(negedge pclk)
        for (int c = 0; c < 4; c++)
            if (p[c] === 1'b1) begin
                if (exp_q[c].size() == 0) chk($sformatf("p%0d_unexpected", c), 1, 0);
                else chk($sformatf("p%0d_time", c), cyc, exp_q[c].pop_front());
            end

    initial begin
        bus.btnL = 1'b1;
        bus.btnR = 1'b1;
        bus.btnD = 1'b1;
        bus.btnU = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            go(k);
            chk("rst_p", p, 0);
            chk("rst_db", db, 0);
        end
        rst = 1'b0;
        push_sched(2, 10, 36, 1'b1, 0, -1);
        push_sched(3, 10, 36, 1'b0, 0, -1);
        go(9);   chk("por_db_lo", db, 4'h0);
        go(10);  chk("por_db_hi", db, 4'hf);
        go(30);
        bus.btnL = 1'b0;
        bus.btnR = 1'b0;
        bus.btnD = 1'b0;
        bus.btnU = 1'b0;
        go(36);  chk("por_rel_hi", db, 4'hf);
        go(37);  chk("por_rel_lo", db, 4'h0);
        go(60);  bus.btnU = 1'b1; exp_q[3].push_back(67);
        go(66);  chk("u_db_pre", db[3], 0);
        go(67);  chk("u_db_rise", db[3], 1);
        go(100); bus.btnU = 1'b0;
        go(106); chk("u_db_hold", db[3], 1);
        go(107); chk("u_db_fall", db[3], 0);
        for (int t = 120; t < 150; t++) begin
            go(t);
            bus.btnL = ((t - 120) % 3 == 0);
            chk("bounce_db", db[0], 0);
        end
        for (int t = 150; t <= 160; t++) begin
            go(t);
            bus.btnL = 1'b0;
            chk("bounce_db_after", db[0], 0);
        end
        go(170); bus.btnD = 1'b1; push_sched(2, 177, 206, 1'b1, 0, -1);
        go(200); bus.btnD = 1'b0;
        go(206); chk("d_db_hold", db[2], 1);
        go(207); chk("d_db_fall", db[2], 0);
        go(215); chk("d_q_empty", exp_q[2].size(), 0);
        go(230); bus.btnL = 1'b1; push_sched(0, 237, 286, 1'b1, 257, 286);
        go(250); bus.btnR = 1'b1; push_sched(1, 257, 300, 1'b1, 257, 286);
        go(257); chk("lr_both_db", db[1:0], 2'b11);
        go(280); bus.btnL = 1'b0;
        go(287); chk("lr_l_released", db[1:0], 2'b10);
        go(300); rst = 1'b1;
        go(301);
        chk("midrst_p", p, 0);
        chk("midrst_db", db, 0);
        rst = 1'b0;
        push_sched(1, 308, 336, 1'b1, 0, -1);
        go(307); chk("r_db_pre", db[1], 0);
        go(308); chk("r_db_rise", db[1], 1);
        go(330); bus.btnR = 1'b0;
        go(337); chk("end_db", db, 4'h0);
        go(360);
        for (int c = 0; c < 4; c++) chk($sformatf("q%0d_empty", c), exp_q[c].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
